// File: rtl/AES_pkg.sv
// AES_pkg: shared AES-128 tables and round helpers for the encryption and
// decryption datapaths, plus the decrypt FSM state type.
// All 128-bit values are [0:127] with byte 0 at [0:7], column-major:
// byte index = row + 4*column.
package AES_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} dec_state_t;

  localparam logic [7:0] S_BOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_S_BOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [0:31] RotWord(input logic [0:31] w);
    return {w[8:31], w[0:7]};
  endfunction

  function automatic logic [0:31] SubWord(input logic [0:31] w);
    logic [0:31] r;
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = S_BOX[w[8*i +: 8]];
    return r;
  endfunction

  // GF(2^8) product modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] MultBytes(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Round key r+1 from round key r.
  function automatic logic [0:127] GetRoundKey(input logic [0:127] rk, input logic [3:0] r);
    logic [0:31] n0, n1, n2, n3;
    n0 = rk[0:31] ^ SubWord(RotWord(rk[96:127])) ^ {RCON[r], 24'h0};
    n1 = rk[32:63] ^ n0;
    n2 = rk[64:95] ^ n1;
    n3 = rk[96:127] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round key r from round key r+1. w1..w3 are recovered first because w0
  // needs the previous key's w3, not the newer one.
  function automatic logic [0:127] InvGetRoundKey(input logic [0:127] rk, input logic [3:0] r);
    logic [0:31] p0, p1, p2, p3;
    p3 = rk[96:127] ^ rk[64:95];
    p2 = rk[64:95] ^ rk[32:63];
    p1 = rk[32:63] ^ rk[0:31];
    p0 = rk[0:31] ^ SubWord(RotWord(p3)) ^ {RCON[r], 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [0:127] InvSubBytes(input logic [0:127] s);
    logic [0:127] o;
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = INV_S_BOX[s[8*i +: 8]];
    return o;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [0:127] InvShiftRows(input logic [0:127] s);
    logic [0:127] o;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + 4 - r) % 4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] InvMixColumns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0] a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c +: 8]      = MultBytes(a0, 8'h0e) ^ MultBytes(a1, 8'h0b) ^ MultBytes(a2, 8'h0d) ^ MultBytes(a3, 8'h09);
      o[32*c + 8 +: 8]  = MultBytes(a0, 8'h09) ^ MultBytes(a1, 8'h0e) ^ MultBytes(a2, 8'h0b) ^ MultBytes(a3, 8'h0d);
      o[32*c + 16 +: 8] = MultBytes(a0, 8'h0d) ^ MultBytes(a1, 8'h09) ^ MultBytes(a2, 8'h0e) ^ MultBytes(a3, 8'h0b);
      o[32*c + 24 +: 8] = MultBytes(a0, 8'h0b) ^ MultBytes(a1, 8'h0d) ^ MultBytes(a2, 8'h09) ^ MultBytes(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round
// (InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last).
// Ports:
//   st_i   [0:127] current state
//   kr_i   [0:127] round key for this round
//   last_i         final round (skip InvMixColumns)
//   st_o   [0:127] next state
module aes_inv_round
  import AES_pkg::*;
(
  input  logic [0:127] st_i,
  input  logic [0:127] kr_i,
  input  logic         last_i,
  output logic [0:127] st_o
);

  logic [0:127] added;

  always_comb begin
    added = InvSubBytes(InvShiftRows(st_i)) ^ kr_i;
    st_o  = last_i ? added : InvMixColumns(added);
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one round per clock.
// Forward key expansion to k10 (10 cycles), then 10 inverse rounds while
// walking the key schedule backwards.
// Optional feature: define AES_DEC_KEY_CACHE_EN to keep the last expanded
// key (k0 -> k10) so a repeated key skips the expansion phase.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid_i/in_ready_o   input handshake (ready only in IDLE)
//   data_i, key_i  [0:127]  ciphertext and cipher key
//   out_valid_o/out_ready_i output handshake
//   data_o         [0:127]  plaintext, held while out_valid_o is high
module aes_decrypt_core
  import AES_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [0:127] data_i,
  input  logic [0:127] key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [0:127] data_o
);

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  dec_state_t   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [0:127] st_q, st_d;
  logic [0:127] rk_q, rk_d;
  logic [0:127] ct_q, ct_d;
  logic [0:127] dout_q, dout_d;
  logic [0:127] fwd_rk, inv_rk, round_out;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [0:127] cache_key_q, cache_key_d;
  logic [0:127] cache_k10_q, cache_k10_d;
  logic         cache_vld_q, cache_vld_d;
`endif

  assign fwd_rk = GetRoundKey(rk_q, cnt_q);
  assign inv_rk = InvGetRoundKey(rk_q, cnt_q);

  aes_inv_round u_round (
    .st_i   (st_q),
    .kr_i   (inv_rk),
    .last_i (cnt_q == 4'd0),
    .st_o   (round_out)
  );

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign data_o      = dout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    dout_d  = dout_q;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    cache_k10_d = cache_k10_q;
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          ct_d    = data_i;
          rk_d    = key_i;
          cnt_d   = '0;
          state_d = KEYEXP;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_vld_q && key_i == cache_key_q) begin
            rk_d    = cache_k10_q;
            st_d    = data_i ^ cache_k10_q;
            cnt_d   = LAST_CNT;
            state_d = ROUND;
          end else begin
            // rk is overwritten during expansion, so the key is captured
            // here; the entry only becomes valid once k10 is known.
            cache_key_d = key_i;
            cache_vld_d = 1'b0;
          end
`endif
        end
      end
      KEYEXP: begin
        rk_d  = fwd_rk;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          st_d    = ct_q ^ fwd_rk;
          cnt_d   = LAST_CNT;
          state_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_k10_d = fwd_rk;
          cache_vld_d = 1'b1;
`endif
        end
      end
      ROUND: begin
        rk_d = inv_rk;
        if (cnt_q == 4'd0) begin
          dout_d  = round_out;
          state_d = DONE;
        end else begin
          st_d  = round_out;
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      dout_q  <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q <= '0;
      cache_k10_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      dout_q  <= dout_d;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_q <= cache_key_d;
      cache_k10_q <= cache_k10_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

endmodule
